// File: rtl/mdio_pkg.sv
// Shared constants for the Clause-22 MDIO master: frame field values, widths
// and the state encoding used by the frame sequencer.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam int PHY_W    = 5;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 16;
    localparam int HDR_BITS = 14;
    localparam int TA_BITS  = 2;
    localparam int FRAME_W  = HDR_BITS + TA_BITS + DATA_W;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_TA   = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_END  = 3'd5;
    localparam logic [2:0] ST_RSP  = 3'd6;

    // Everything after the preamble, MSB first; TA/DATA are ignored on reads.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rd,
        input logic [PHY_W-1:0]  phy,
        input logic [REG_W-1:0]  rg,
        input logic [DATA_W-1:0] wd
    );
        return {MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR), phy, rg, MDIO_TA_WR, wd};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: mdc starts low when enabled, toggles every MDC_DIV clk, and
// flags the cycles in which it is about to rise or fall.
module mdio_clk_gen #(
    parameter int MDC_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_mdc,
    output logic o_rise,
    output logic o_fall
);

    logic [7:0] r_cnt;
    logic       r_mdc;
    logic       w_tc;

    assign w_tc = (r_cnt == 8'(MDC_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_mdc <= ~r_mdc;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_mdc  = r_mdc;
    assign o_rise = i_en & w_tc & ~r_mdc;
    assign o_fall = i_en & w_tc & r_mdc;

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: accepts one command at a time, serialises the frame
// against a divided MDC and returns read data / TA error as a one-clk response.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int MDC_DIV      = 4,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        mdio_in
);

    logic [2:0]         r_state;
    logic [7:0]         r_bit_cnt;
    logic [FRAME_W-1:0] r_frame;
    logic               r_read;
    logic [DATA_W-1:0]  r_shift;
    logic               r_ta_err;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_error;
    logic               r_mdio_out;
    logic               r_mdio_oen;

    logic w_en;
    logic w_rise;
    logic w_fall;
    logic w_last;
    logic w_next_drv;

    assign w_en = (r_state != ST_IDLE) && (r_state != ST_RSP);

    mdio_clk_gen #(.MDC_DIV(MDC_DIV)) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_en),
        .o_mdc  (mdc),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            ST_PRE:  w_last = (r_bit_cnt == 8'(PREAMBLE_LEN - 1));
            ST_HDR:  w_last = (r_bit_cnt == 8'(HDR_BITS - 1));
            ST_TA:   w_last = (r_bit_cnt == 8'(TA_BITS - 1));
            ST_DATA: w_last = (r_bit_cnt == 8'(DATA_W - 1));
            default: w_last = 1'b0;
        endcase
    end

    // Reads hand the line to the PHY from the first TA bit onwards.
    assign w_next_drv = !r_read || ((r_state == ST_HDR) && !w_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_frame     <= '0;
            r_read      <= 1'b0;
            r_shift     <= '0;
            r_ta_err    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_mdio_out  <= 1'b1;
            r_mdio_oen  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_frame    <= build_frame(cmd_read, cmd_phy_addr, cmd_reg_addr, cmd_wdata);
                        r_read     <= cmd_read;
                        r_bit_cnt  <= '0;
                        r_ta_err   <= 1'b0;
                        r_mdio_oen <= 1'b1;
                        if (PREAMBLE_LEN > 0) begin
                            r_state    <= ST_PRE;
                            r_mdio_out <= 1'b1;
                        end else begin
                            r_state    <= ST_HDR;
                            r_mdio_out <= MDIO_ST[1];
                        end
                    end
                end
                ST_PRE: begin
                    if (w_fall) begin
                        if (w_last) begin
                            r_state    <= ST_HDR;
                            r_bit_cnt  <= '0;
                            r_mdio_out <= r_frame[FRAME_W-1];
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                end
                ST_HDR, ST_TA, ST_DATA: begin
                    if (w_rise && r_read) begin
                        if ((r_state == ST_TA) && w_last) r_ta_err <= mdio_in;
                        if (r_state == ST_DATA) r_shift <= {r_shift[DATA_W-2:0], mdio_in};
                    end
                    if (w_fall) begin
                        r_frame   <= r_frame << 1;
                        r_bit_cnt <= w_last ? 8'd0 : r_bit_cnt + 8'd1;
                        if ((r_state == ST_DATA) && w_last) begin
                            r_state    <= ST_END;
                            r_mdio_out <= 1'b1;
                            r_mdio_oen <= 1'b0;
                        end else begin
                            if (w_last) r_state <= (r_state == ST_HDR) ? ST_TA : ST_DATA;
                            r_mdio_out <= w_next_drv ? r_frame[FRAME_W-2] : 1'b1;
                            r_mdio_oen <= w_next_drv;
                        end
                    end
                end
                ST_END: begin
                    if (w_fall) begin
                        r_state <= ST_RSP;
                        if (r_read) begin
                            r_rsp_rdata <= r_shift;
                            r_rsp_error <= r_ta_err;
                        end else begin
                            r_rsp_error <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RSP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign mdio_out  = r_mdio_out;
    assign mdio_oen  = r_mdio_oen;

endmodule
